// File: rtl/max7219_display_driver_if.sv
// Three-wire write-only SPI link from the display driver to a MAX7219 controller.
interface max7219_display_driver_if;
    logic Mosi;
    logic Cs;
    logic Clk_SPI;

    modport master (output Mosi, output Cs, output Clk_SPI);
    modport slave  (input  Mosi, input  Cs, input  Clk_SPI);
endinterface

// File: rtl/max7219_display_driver.sv
// MAX7219 driver: one init batch after reset, then an 8-frame digit refresh per enabled
// clk_div rising edge, using digits snapshotted when the batch starts.
module max7219_display_driver #(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [3:0]  INTENSITY  = 4'h8,
    parameter logic [2:0]  SCAN_LIMIT = 3'd7
) (
    input  logic       clk,
    input  logic       res,
    input  logic       clk_div,
    input  logic       ena,
    input  logic [2:0] min_X0,
    input  logic [3:0] min_0X,
    input  logic [2:0] sec_X0,
    input  logic [3:0] sec_0X,
    input  logic [3:0] ces_X0,
    input  logic [3:0] ces_0X,
    max7219_display_driver_if.master spi,
    output logic       busy
);
    localparam int unsigned CNT_W = 9;
    localparam logic [CNT_W-1:0] DIV  = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] DIV2 = CNT_W'(2 * CLK_DIV);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, HOLD, GAP} state_t;

    typedef struct packed {
        logic [2:0] min_x0;
        logic [3:0] min_0x;
        logic [2:0] sec_x0;
        logic [3:0] sec_0x;
        logic [3:0] ces_x0;
        logic [3:0] ces_0x;
    } digits_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       bit_n, bit_d;
    logic [2:0]       idx, idx_d;
    logic             init_run, init_run_d;
    logic             init_armed, init_armed_d;
    logic             pending, pending_d;
    logic             clk_div_prev;
    digits_t          snap, snap_d, live;
    logic             rise;
    logic [2:0]       last_idx;
    logic [15:0]      word_d;
    logic             mosi_d, cs_d, sclk_d;

    assign live = {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X};

    // Frame contents for a given batch kind and position.
    function automatic logic [15:0] frame_word(input logic init, input logic [2:0] i,
                                               input digits_t s);
        logic [15:0] w;
        w = 16'h0000;
        if (init) begin
            case (i)
                3'd0:    w = 16'h0C01;
                3'd1:    w = 16'h09FF;
                3'd2:    w = {8'h0B, 5'b0, SCAN_LIMIT};
                3'd3:    w = {8'h0A, 4'b0, INTENSITY};
                default: w = 16'h0F00;
            endcase
        end else begin
            case (i)
                3'd0:    w = {8'h01, 4'h0, s.ces_0x};
                3'd1:    w = {8'h02, 4'h0, s.ces_x0};
                3'd2:    w = {8'h03, 1'b1, 3'b0, s.sec_0x};
                3'd3:    w = {8'h04, 5'b0, s.sec_x0};
                3'd4:    w = {8'h05, 1'b1, 3'b0, s.min_0x};
                3'd5:    w = {8'h06, 5'b0, s.min_x0};
                3'd6:    w = 16'h070F;
                default: w = 16'h080F;
            endcase
        end
        return w;
    endfunction

    // Next state; LOAD is the first cycle of the frame (Cs low, bit 15 on Mosi).
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        bit_d        = bit_n;
        idx_d        = idx;
        init_run_d   = init_run;
        init_armed_d = init_armed;
        pending_d    = pending;
        snap_d       = snap;
        rise         = clk_div & ~clk_div_prev;
        last_idx     = init_run ? 3'd4 : 3'd7;

        if (rise && ena && state != IDLE) pending_d = 1'b1;

        case (state)
            IDLE: begin
                if (init_armed) begin
                    init_armed_d = 1'b0;
                    init_run_d   = 1'b1;
                    idx_d        = 3'd0;
                    state_d      = LOAD;
                    if (rise && ena) pending_d = 1'b1;
                end else if (pending || (rise && ena)) begin
                    pending_d  = 1'b0;
                    snap_d     = live;
                    init_run_d = 1'b0;
                    idx_d      = 3'd0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                bit_d   = 4'd0;
                cnt_d   = CNT_W'(1);
            end
            SHIFT: begin
                if (cnt == DIV2 - 1'b1) begin
                    cnt_d = '0;
                    if (bit_n == 4'd15) state_d = HOLD;
                    else                bit_d   = bit_n + 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == DIV - 1'b1) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == DIV2 - 1'b1) begin
                    cnt_d = '0;
                    if (idx != last_idx) begin
                        idx_d   = idx + 1'b1;
                        state_d = LOAD;
                    end else if (pending || (rise && ena)) begin
                        pending_d  = 1'b0;
                        snap_d     = live;
                        init_run_d = 1'b0;
                        idx_d      = 3'd0;
                        state_d    = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin values for the upcoming cycle, derived from the next state.
        word_d = frame_word(init_run_d, idx_d, snap_d);
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        case (state_d)
            LOAD: begin
                cs_d   = 1'b0;
                mosi_d = word_d[15];
            end
            SHIFT: begin
                cs_d   = 1'b0;
                sclk_d = (cnt_d >= DIV);
                mosi_d = word_d[~bit_d];
            end
            HOLD:    cs_d = 1'b0;
            default: cs_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_n        <= '0;
            idx          <= '0;
            init_run     <= 1'b0;
            init_armed   <= 1'b1;
            pending      <= 1'b0;
            clk_div_prev <= 1'b0;
            snap         <= '0;
            spi.Cs       <= 1'b1;
            spi.Clk_SPI  <= 1'b0;
            spi.Mosi     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            bit_n        <= bit_d;
            idx          <= idx_d;
            init_run     <= init_run_d;
            init_armed   <= init_armed_d;
            pending      <= pending_d;
            clk_div_prev <= clk_div;
            snap         <= snap_d;
            spi.Cs       <= cs_d;
            spi.Clk_SPI  <= sclk_d;
            spi.Mosi     <= mosi_d;
            busy         <= (state_d != IDLE);
        end
    end
endmodule
